// File: rtl/batchnorm_pkg.sv
// Shared definitions for the BatchNorm channel sequencer: default sizes and FSM states.
package batchnorm_pkg;

   localparam int BN_DATA_W = 16;
   localparam int BN_LOG2_N = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACC  = 3'd1,
      ST_STAT = 3'd2,
      ST_NORM = 3'd3,
      ST_FIN  = 3'd4
   } bn_state_e;

   function automatic logic state_busy(input bn_state_e st);
      return (st != ST_IDLE);
   endfunction

endpackage

// File: rtl/batchnorm_stat_calc.sv
// Channel statistics from the accumulated sums: floor mean and variance clamped at zero.
module batchnorm_stat_calc
   import batchnorm_pkg::*;
#(
   parameter int DATA_W = BN_DATA_W,
   parameter int LOG2_N = BN_LOG2_N
) (
   input  logic signed [DATA_W+LOG2_N-1:0]   sum_i,
   input  logic        [2*DATA_W+LOG2_N-1:0] sumsq_i,
   output logic signed [DATA_W-1:0]          mean_o,
   output logic        [2*DATA_W-1:0]        var_o
);

   logic signed [2*DATA_W-1:0] mean_ext_s;
   logic signed [2*DATA_W-1:0] msq_s;
   logic        [2*DATA_W-1:0] ex2_s;
   logic signed [2*DATA_W:0]   diff_s;

   // Dropping the low LOG2_N bits of a signed sum is an arithmetic shift, i.e. a floor divide.
   always_comb begin
      mean_o     = sum_i[DATA_W+LOG2_N-1:LOG2_N];
      mean_ext_s = {{DATA_W{sum_i[DATA_W+LOG2_N-1]}}, sum_i[DATA_W+LOG2_N-1:LOG2_N]};
      msq_s      = mean_ext_s * mean_ext_s;
      ex2_s      = sumsq_i[2*DATA_W+LOG2_N-1:LOG2_N];
      diff_s     = {1'b0, ex2_s} - {1'b0, msq_s};
      if (diff_s[2*DATA_W]) begin
         var_o = '0;
      end else begin
         var_o = diff_s[2*DATA_W-1:0];
      end
   end

endmodule

// File: rtl/batchnorm_seq_ctrl.sv
// Two-pass BatchNorm channel sequencer: accumulate statistics, then stream elements out.
module batchnorm_seq_ctrl
   import batchnorm_pkg::*;
#(
   parameter int DATA_W = BN_DATA_W,
   parameter int LOG2_N = BN_LOG2_N
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       rd_en,
   output logic [LOG2_N-1:0]          rd_addr,
   input  logic signed [DATA_W-1:0]   rd_data,
   output logic                       norm_valid,
   input  logic                       norm_ready,
   output logic signed [DATA_W-1:0]   norm_data,
   output logic signed [DATA_W-1:0]   mean_out,
   output logic [2*DATA_W-1:0]        var_out
);

   localparam int SUM_W = DATA_W + LOG2_N;
   localparam int SQ_W  = 2*DATA_W + LOG2_N;
   localparam logic [LOG2_N:0] N_C    = {1'b1, {LOG2_N{1'b0}}};
   localparam logic [LOG2_N:0] LAST_C = {1'b0, {LOG2_N{1'b1}}};
   localparam logic [LOG2_N:0] ONE_C  = {{LOG2_N{1'b0}}, 1'b1};

   bn_state_e                 state_q, state_d;
   logic [LOG2_N:0]           rd_cnt_q, rd_cnt_d;
   logic [LOG2_N:0]           elem_cnt_q, elem_cnt_d;
   logic                      pend_q, pend_d;
   logic signed [SUM_W-1:0]   sum_q, sum_d;
   logic [SQ_W-1:0]           sumsq_q, sumsq_d;
   logic signed [DATA_W-1:0]  norm_data_q, norm_data_d;
   logic                      norm_valid_q, norm_valid_d;
   logic signed [DATA_W-1:0]  mean_q, mean_d;
   logic [2*DATA_W-1:0]       var_q, var_d;

   logic signed [DATA_W-1:0]  stat_mean_s;
   logic [2*DATA_W-1:0]       stat_var_s;
   logic signed [2*DATA_W-1:0] rd_ext_s;
   logic signed [2*DATA_W-1:0] sq_s;
   logic                      rd_en_s;
   logic                      xfer_s;
   logic                      acc_last_s;
   logic                      xfer_last_s;

   batchnorm_stat_calc #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) u_stat (
      .sum_i   (sum_q),
      .sumsq_i (sumsq_q),
      .mean_o  (stat_mean_s),
      .var_o   (stat_var_s)
   );

   assign rd_ext_s    = {{DATA_W{rd_data[DATA_W-1]}}, rd_data};
   assign sq_s        = rd_ext_s * rd_ext_s;
   assign xfer_s      = norm_valid_q && norm_ready;
   assign acc_last_s  = (state_q == ST_ACC) && pend_q && (elem_cnt_q == LAST_C);
   assign xfer_last_s = (state_q == ST_NORM) && xfer_s && (elem_cnt_q == LAST_C);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (acc_last_s) begin
               state_d = ST_STAT;
            end else begin
               state_d = ST_ACC;
            end
         end
         ST_STAT: state_d = ST_NORM;
         ST_NORM: begin
            if (xfer_last_s) begin
               state_d = ST_FIN;
            end else begin
               state_d = ST_NORM;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; in NORM a read is only launched when its result has somewhere to land.
   always_comb begin
      busy    = state_busy(state_q);
      done    = (state_q == ST_FIN);
      rd_addr = rd_cnt_q[LOG2_N-1:0];
      case (state_q)
         ST_ACC:  rd_en_s = (rd_cnt_q != N_C);
         ST_NORM: rd_en_s = !pend_q && (rd_cnt_q != N_C) && (!norm_valid_q || norm_ready);
         default: rd_en_s = 1'b0;
      endcase
   end

   assign rd_en = rd_en_s;

   // Datapath next-state: counters, accumulators, output register and captured statistics.
   always_comb begin
      rd_cnt_d     = rd_cnt_q;
      elem_cnt_d   = elem_cnt_q;
      sum_d        = sum_q;
      sumsq_d      = sumsq_q;
      norm_data_d  = norm_data_q;
      norm_valid_d = norm_valid_q;
      mean_d       = mean_q;
      var_d        = var_q;
      pend_d       = rd_en_s;
      case (state_q)
         ST_IDLE: begin
            rd_cnt_d   = '0;
            elem_cnt_d = '0;
            if (start) begin
               sum_d   = '0;
               sumsq_d = '0;
            end else begin
               sum_d   = sum_q;
               sumsq_d = sumsq_q;
            end
         end
         ST_ACC: begin
            if (rd_en_s) begin
               rd_cnt_d = rd_cnt_q + ONE_C;
            end else begin
               rd_cnt_d = rd_cnt_q;
            end
            if (pend_q) begin
               sum_d      = sum_q + {{LOG2_N{rd_data[DATA_W-1]}}, rd_data};
               sumsq_d    = sumsq_q + {{LOG2_N{1'b0}}, sq_s};
               elem_cnt_d = elem_cnt_q + ONE_C;
            end else begin
               elem_cnt_d = elem_cnt_q;
            end
         end
         ST_STAT: begin
            mean_d     = stat_mean_s;
            var_d      = stat_var_s;
            rd_cnt_d   = '0;
            elem_cnt_d = '0;
         end
         ST_NORM: begin
            if (rd_en_s) begin
               rd_cnt_d = rd_cnt_q + ONE_C;
            end else begin
               rd_cnt_d = rd_cnt_q;
            end
            if (pend_q) begin
               norm_data_d  = rd_data;
               norm_valid_d = 1'b1;
            end else if (xfer_s) begin
               norm_valid_d = 1'b0;
            end else begin
               norm_valid_d = norm_valid_q;
            end
            if (xfer_s) begin
               elem_cnt_d = elem_cnt_q + ONE_C;
            end else begin
               elem_cnt_d = elem_cnt_q;
            end
         end
         ST_FIN: begin
            rd_cnt_d     = '0;
            elem_cnt_d   = '0;
            norm_valid_d = 1'b0;
         end
         default: begin
            rd_cnt_d   = '0;
            elem_cnt_d = '0;
         end
      endcase
   end

   // Datapath registers; reset clears the in-flight flag so stale read data is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q     <= '0;
         elem_cnt_q   <= '0;
         pend_q       <= 1'b0;
         sum_q        <= '0;
         sumsq_q      <= '0;
         norm_data_q  <= '0;
         norm_valid_q <= 1'b0;
         mean_q       <= '0;
         var_q        <= '0;
      end else begin
         rd_cnt_q     <= rd_cnt_d;
         elem_cnt_q   <= elem_cnt_d;
         pend_q       <= pend_d;
         sum_q        <= sum_d;
         sumsq_q      <= sumsq_d;
         norm_data_q  <= norm_data_d;
         norm_valid_q <= norm_valid_d;
         mean_q       <= mean_d;
         var_q        <= var_d;
      end
   end

   assign norm_valid = norm_valid_q;
   assign norm_data  = norm_data_q;
   assign mean_out   = mean_q;
   assign var_out    = var_q;

endmodule

// File: tb/tb_batchnorm_seq_ctrl.sv
// Directed table-driven bench for batchnorm_seq_ctrl with a one-cycle-latency buffer model.
module tb_batchnorm_seq_ctrl;

   localparam int DW = 16;
   localparam int LN = 4;
   localparam int N  = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 norm_ready = 1'b0;
   logic                 busy, done, rd_en, norm_valid;
   logic [LN-1:0]        rd_addr;
   logic signed [DW-1:0] rd_data;
   logic signed [DW-1:0] norm_data;
   logic signed [DW-1:0] mean_out;
   logic [2*DW-1:0]      var_out;

   logic signed [DW-1:0] mem [N];

   int errors = 0;
   int checks = 0;

   typedef struct {
      int     even_v;
      int     odd_v;
      int     step;
      int     stall_at;
      bit     spur;
      int     exp_mean;
      longint exp_var;
   } vec_t;

   vec_t vecs [9];

   batchnorm_seq_ctrl #(.DATA_W(DW), .LOG2_N(LN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .norm_valid (norm_valid),
      .norm_ready (norm_ready),
      .norm_data  (norm_data),
      .mean_out   (mean_out),
      .var_out    (var_out)
   );

   always #5 clk = ~clk;

   // Element buffer: data appears one cycle after the address is presented.
   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int elem(input int v, input int i);
      return (((i % 2) == 0) ? vecs[v].even_v : vecs[v].odd_v) + vecs[v].step * i;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},       busy, 0);
      chk({tag, "_done"},       done, 0);
      chk({tag, "_rd_en"},      rd_en, 0);
      chk({tag, "_rd_addr"},    rd_addr, 0);
      chk({tag, "_norm_valid"}, norm_valid, 0);
      chk({tag, "_norm_data"},  norm_data, 0);
      chk({tag, "_mean"},       mean_out, 0);
      chk({tag, "_var"},        var_out, 0);
   endtask

   task automatic run_channel(input int v);
      int xfers = 0;
      int reads = 0;
      int dones = 0;
      int cyc = 0;
      int last_xfer = -10;
      int done_cyc = -1;
      int stall_cnt = 0;
      for (int i = 0; i < N; i++) mem[i] = 16'(elem(v, i));
      @(negedge clk);
      start = 1'b1;
      norm_ready = 1'b1;
      while (done_cyc < 0 && cyc < 300) begin
         @(negedge clk);
         start = vecs[v].spur && (cyc == 4 || cyc == 40);
         if (vecs[v].stall_at == xfers && norm_valid && stall_cnt < 5) begin
            norm_ready = 1'b0;
            stall_cnt++;
         end else begin
            norm_ready = 1'b1;
         end
         #1;
         if (cyc == 0) begin
            chk("first_rd_en", rd_en, 1);
            chk("first_busy", busy, 1);
         end
         if (rd_en) begin
            chk("rd_addr", rd_addr, reads % N);
            reads++;
         end
         if (norm_valid && !norm_ready) begin
            chk("stall_no_rd", rd_en, 0);
            chk("stall_hold", norm_data, elem(v, xfers));
         end
         if (norm_valid && norm_ready) begin
            chk("norm_data", norm_data, elem(v, xfers));
            xfers++;
            last_xfer = cyc;
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
            chk("mean_out", mean_out, vecs[v].exp_mean);
            chk("var_out", var_out, vecs[v].exp_var);
         end
         cyc++;
      end
      chk("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
      chk("done_latency", done_cyc - last_xfer, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = 1'b0;
         norm_ready = 1'b1;
         #1;
         if (done) dones++;
      end
      chk("xfer_count", xfers, N);
      chk("read_count", reads, 2 * N);
      chk("done_count", dones, 1);
      chk("idle_after", busy, 0);
      chk("mean_hold", mean_out, vecs[v].exp_mean);
   endtask

   initial begin
      int reads;
      vecs[0] = '{3,      3,      0, -1, 1'b0, 3,      64'd0};
      vecs[1] = '{0,      0,      1, -1, 1'b0, 7,      64'd28};
      vecs[2] = '{4,      -4,     0, -1, 1'b0, 0,      64'd16};
      vecs[3] = '{0,      0,      1,  7, 1'b0, 7,      64'd28};
      vecs[4] = '{4,      -4,     0, -1, 1'b1, 0,      64'd16};
      vecs[5] = '{-1,     0,      0, -1, 1'b0, -1,     64'd0};
      vecs[6] = '{10,     -6,     0, -1, 1'b0, 2,      64'd64};
      vecs[7] = '{32767,  32767,  0, -1, 1'b0, 32767,  64'd0};
      vecs[8] = '{-32768, -32768, 0, -1, 1'b0, -32768, 64'd0};
      for (int i = 0; i < N; i++) mem[i] = '0;

      @(negedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 9; v++) run_channel(v);

      // Reset in the middle of the accumulation pass, then a clean channel.
      for (int i = 0; i < N; i++) mem[i] = 16'(i);
      @(negedge clk);
      start = 1'b1;
      reads = 0;
      for (int c = 0; c < 50 && reads < 6; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (rd_en) reads++;
      end
      chk("mid_acc_reads", reads, 6);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_acc");
      #1;
      rst_n = 1'b1;
      run_channel(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/batchnorm_seq_ctrl.md
BATCHNORM_SEQ_CTRL -- requirements
Module: batchnorm_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, signed element width.
REQ-002 Parameter LOG2_N, default 4; elements per channel N = 2**LOG2_N.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to process one channel; sampled only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse when the channel has been fully emitted.
REQ-008 rd_en  output  1  element-buffer read strobe.
REQ-009 rd_addr  output  LOG2_N  element index for the read.
REQ-010 rd_data  input  DATA_W  signed read data, valid exactly 1 cycle after rd_en.
REQ-011 norm_valid  output  1  element presented to the BatchNorm datapath.
REQ-012 norm_ready  input  1  datapath accepts; transfer when norm_valid && norm_ready.
REQ-013 norm_data  output  DATA_W  element for the datapath.
REQ-014 mean_out  output  DATA_W  channel mean, stable from STAT exit until next start.
REQ-015 var_out  output  2*DATA_W  channel variance, same stability as mean_out.

Function
REQ-016 FSM states IDLE, ACC, STAT, NORM, FIN; IDLE->ACC on start; ACC->STAT after the Nth rd_data is accumulated; STAT->NORM after 1 cycle; NORM->FIN after the Nth transfer; FIN->IDLE after 1 cycle with done=1.
REQ-017 ACC: rd_en=1 for exactly N consecutive cycles, rd_addr 0..N-1 ascending; rd_addr wraps to 0 with no extra read.
REQ-018 ACC: sum (signed, DATA_W+LOG2_N bits) += rd_data; sumsq (unsigned, 2*DATA_W+LOG2_N bits) += rd_data*rd_data; both cleared on IDLE->ACC.
REQ-019 STAT: mean = sum >>> LOG2_N (arithmetic, floor); ex2 = sumsq >> LOG2_N; var = ex2 - mean*mean, clamped to 0 if negative; registered into mean_out/var_out.
REQ-020 NORM: second pass rd_addr 0..N-1; at most one read in flight; rd_en=1 only when no read in flight, reads issued < N, and output register empty or being consumed this cycle.
REQ-021 NORM: returned rd_data loads norm_data with norm_valid=1; norm_data/norm_valid hold unchanged while norm_valid && !norm_ready.
REQ-022 Latency: start to first rd_en = 1 cycle; last transfer to done = 1 cycle.
REQ-023 start outside IDLE is ignored; start in FIN is ignored.
REQ-024 norm_ready while norm_valid=0 has no effect.

Reset
REQ-025 On rst_n=0 (any state, incl. mid-ACC/NORM): state=IDLE, busy=0, done=0, rd_en=0, rd_addr=0, norm_valid=0, norm_data=0, mean_out=0, var_out=0, sum=0, sumsq=0, counters=0.
REQ-026 Read data returning after reset deassertion from a pre-reset read is discarded.

Structure
REQ-027 FSM state enum and default DATA_W/LOG2_N constants live in a shared batchnorm package.
REQ-028 Statistics arithmetic (REQ-019) is one sub-module, batchnorm_stat_calc, combinational, registered by the parent.

Verification
REQ-029 N=16, all elements 3 -> mean_out=3, var_out=0, 16 transfers of 3, one done pulse.
REQ-030 Elements 0..15 -> sum=120, mean_out=7, sumsq=1240, ex2=77, var_out=28; norm_data sequence 0..15.
REQ-031 Alternating +4/-4 -> mean_out=0, var_out=16; negative values emitted sign-correct.
REQ-032 norm_ready low 5 cycles at element 7 -> norm_data=7 held stable, no rd_en while stalled, no loss/duplication.
REQ-033 rst_n low in ACC after 6 reads -> all outputs zero next cycle; a new start gives correct stats with no residue.
REQ-034 start pulsed in ACC and NORM -> ignored; exactly one done per accepted start.
